vga_capture: RTL and testbench
==============================

# vga_capture

Receive-side counterpart of the VGA timing generator: samples an incoming active-low-sync VGA stream (RGB, HS, VS, BLANK_N), locks to its frame structure and writes every visible pixel into a COLS x ROWS frame buffer as a linear address plus a truncated colour word. It sits between a VGA-format source and the video memory write port. It also serves as the in-system checker for our own video timing.

## Interface
- RESOLUTION, "640x480", informational; must match COLS/ROWS
- COLOR_DEPTH, 9, bits per stored pixel; BITS_PER_RGB = COLOR_DEPTH/3
- nX, 10, x counter width
- nY, 9, y counter width
- Mn, 19, memory address width
- COLS, 640, visible pixels per line
- ROWS, 480, visible lines per frame
- DATA_DELAY, 2, cycles RGB is delayed to align with BLANK_N/HS/VS (0..3)

Ports:
- vga_clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high
- VGA_R, VGA_G, VGA_B  in  8 each  pixel data
- VGA_HS, VGA_VS  in  1  sync, active low
- VGA_BLANK_N  in  1  high = visible pixel
- memory_address  out  Mn  write address, y*COLS + x
- pixel_color  out  COLOR_DEPTH  {R msbs, G msbs, B msbs}, BITS_PER_RGB each
- write_enable  out  1  one pulse per captured pixel
- locked  out  1  timing verified, capture active
- frame_done  out  1  1-cycle pulse: a complete valid frame was written
- timing_error  out  1  1-cycle pulse: frame failed the geometry check

## Operation
- Input stage: HS, VS and BLANK_N registered once (s1). RGB passes a DATA_DELAY-deep shift register, then the same register, so s1 RGB pairs with s1 BLANK_N.
- Events from s1 vs previous s1: vs_fall (VS 1->0), line_end (BLANK_N 1->0).
- x counter: +1 per cycle with s1 BLANK_N high, cleared on line_end; saturates at 2^nX-1. Line is bad if x != COLS at line_end.
- line counter: +1 per line_end, cleared on vs_fall; saturates at 2^nY-1. Any bad line sets a sticky bad_frame flag, cleared on vs_fall.
- Frame check at vs_fall: valid iff line count == ROWS and bad_frame clear.
- FSM:
  - SEARCH: wait for vs_fall -> MEASURE. No writes.
  - MEASURE: at vs_fall, valid -> LOCKED; invalid -> stay MEASURE and pulse timing_error. No writes.
  - LOCKED: write every s1 visible pixel. At vs_fall: valid -> stay and pulse frame_done; invalid -> MEASURE and pulse timing_error.
- Address counter: cleared on vs_fall; +1 after each write; saturates at COLS*ROWS-1. Writes continue while address is saturated.
- Writes in LOCKED happen before the frame is validated; frame_done is the only commit indication.
- pixel_color = {R[7 -: B], G[7 -: B], B[7 -: B]}, where B = BITS_PER_RGB.

## Timing
- Reset (asynchronous, any time): state SEARCH; all counters 0. All outputs 0: memory_address, pixel_color, write_enable, locked, frame_done, timing_error.
- All outputs are registered from s1.
- Latency:
  - VGA_BLANK_N high at input -> write_enable high 2 cycles later.
  - Input RGB -> pixel_color DATA_DELAY+2 cycles later.
- locked, frame_done and timing_error update 2 cycles after the VS falling edge at the input.
- locked reflects state==LOCKED, lagging the state by the output register.
- Simultaneous vs_fall and line_end: line_end is counted first, then the frame check runs on the updated count.
- VS held low for multiple cycles: exactly one vs_fall.
- A visible pixel inside the VS pulse is still written in LOCKED.

## Test plan
- Reset: assert reset mid-stream -> same cycle, all outputs 0. After release, no write_enable until a full MEASURE frame completes.
- Clean 800x525 frames, HS 659..754, VS 493..494, visible 640x480, driven by the timing generator:
  - locked rises 2 cycles after the 2nd VS fall.
  - The next frame gives exactly 307200 write_enable pulses, addresses 0..307199 in order.
  - frame_done pulses once at the 3rd VS fall; timing_error never pulses.
- Colour: R=8'hE0, G=8'h1F, B=8'hA5 on pixel (0,0) -> pixel_color=9'b111000101 at memory_address 0, aligned with its write_enable.
- Short line (639 visible) in a locked frame:
  - timing_error pulses and locked drops at the next VS fall; no frame_done.
  - locked returns after one clean frame.
- Geometry errors: a 641-pixel line, or a frame with 481 lines, in MEASURE -> timing_error pulse, state stays MEASURE, no writes.
- DATA_DELAY sweep 0..3 with matching source skew -> a pixel-value ramp lands at address == x on line 0.

Source files
------------

// File: rtl/vga_capture_if.sv
// Frame-buffer write port: linear address, truncated colour word and a write strobe.
interface vga_capture_if #(
  parameter int Mn          = 19,
  parameter int COLOR_DEPTH = 9
);
  logic [Mn-1:0]          memory_address;
  logic [COLOR_DEPTH-1:0] pixel_color;
  logic                   write_enable;

  modport master (output memory_address, pixel_color, write_enable);
  modport slave  (input  memory_address, pixel_color, write_enable);
endinterface

// File: rtl/vga_capture.sv
// VGA receiver: locks to an active-low-sync stream, verifies frame geometry and
// writes visible pixels into a COLS x ROWS frame buffer.
module vga_capture #(
  parameter     RESOLUTION  = "640x480",
  parameter int COLOR_DEPTH = 9,
  parameter int nX          = 10,
  parameter int nY          = 9,
  parameter int Mn          = 19,
  parameter int COLS        = 640,
  parameter int ROWS        = 480,
  parameter int DATA_DELAY  = 2
) (
  input  logic          vga_clock,
  input  logic          reset,
  input  logic [7:0]    VGA_R,
  input  logic [7:0]    VGA_G,
  input  logic [7:0]    VGA_B,
  input  logic          VGA_HS,
  input  logic          VGA_VS,
  input  logic          VGA_BLANK_N,
  vga_capture_if.master mem,
  output logic          locked,
  output logic          frame_done,
  output logic          timing_error
);
  localparam int BITS_PER_RGB = COLOR_DEPTH / 3;
  localparam int PW           = 3 * BITS_PER_RGB;

  localparam logic [nX-1:0] X_MAX  = '1;
  localparam logic [nX-1:0] X_COLS = nX'(COLS);
  localparam logic [nY-1:0] Y_MAX  = '1;
  localparam logic [nY-1:0] Y_ROWS = nY'(ROWS);
  localparam logic [Mn-1:0] A_MAX  = Mn'(COLS * ROWS - 1);

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_MEASURE,
    ST_LOCKED
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] rgb_in;
  logic [PW-1:0] rgb_pipe [DATA_DELAY+1];
  logic [PW-1:0] rgb_s1;

  logic hs_s1, vs_s1, blank_s1;
  logic vs_s2, blank_s2;
  logic vs_fall, line_end;

  logic [nX-1:0] x_cnt;
  logic [nY-1:0] line_cnt, line_upd;
  logic          bad_frame, bad_upd, frame_ok;
  logic [Mn-1:0] addr;
  logic          wr, fd_d, te_d;

  logic          we_q;
  logic [Mn-1:0] addr_q;
  logic [PW-1:0] pix_q;

  logic unused_lsbs, unused_misc;

  assign rgb_in = {VGA_R[7 -: BITS_PER_RGB], VGA_G[7 -: BITS_PER_RGB], VGA_B[7 -: BITS_PER_RGB]};

  if (BITS_PER_RGB < 8) begin : g_lsbs
    assign unused_lsbs = ^{VGA_R[7-BITS_PER_RGB:0], VGA_G[7-BITS_PER_RGB:0], VGA_B[7-BITS_PER_RGB:0]};
  end else begin : g_no_lsbs
    assign unused_lsbs = 1'b0;
  end
  assign unused_misc = ^{unused_lsbs, hs_s1, RESOLUTION};

  // RGB runs DATA_DELAY stages ahead of the sync/blank register so both leave s1 together.
  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i <= DATA_DELAY; i++) rgb_pipe[i] <= '0;
    end else begin
      rgb_pipe[0] <= rgb_in;
      for (int unsigned i = 1; i <= DATA_DELAY; i++) rgb_pipe[i] <= rgb_pipe[i-1];
    end
  end
  assign rgb_s1 = rgb_pipe[DATA_DELAY];

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      hs_s1    <= 1'b1;
      vs_s1    <= 1'b1;
      blank_s1 <= 1'b0;
      vs_s2    <= 1'b1;
      blank_s2 <= 1'b0;
    end else begin
      hs_s1    <= VGA_HS;
      vs_s1    <= VGA_VS;
      blank_s1 <= VGA_BLANK_N;
      vs_s2    <= vs_s1;
      blank_s2 <= blank_s1;
    end
  end

  assign vs_fall  = vs_s2 & ~vs_s1;
  assign line_end = blank_s2 & ~blank_s1;

  // A line ending on the vs_fall cycle is counted before the frame is judged.
  always_comb begin
    line_upd = line_cnt;
    if (line_end && line_cnt != Y_MAX) line_upd = line_cnt + 1'b1;
    bad_upd  = bad_frame | (line_end && x_cnt != X_COLS);
    frame_ok = (line_upd == Y_ROWS) && !bad_upd;
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      x_cnt     <= '0;
      line_cnt  <= '0;
      bad_frame <= 1'b0;
    end else begin
      if (line_end)                          x_cnt <= '0;
      else if (blank_s1 && x_cnt != X_MAX)   x_cnt <= x_cnt + 1'b1;
      line_cnt  <= vs_fall ? '0   : line_upd;
      bad_frame <= vs_fall ? 1'b0 : bad_upd;
    end
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) state_q <= ST_SEARCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    fd_d    = 1'b0;
    te_d    = 1'b0;
    if (vs_fall) begin
      unique case (state_q)
        ST_SEARCH:  state_d = ST_MEASURE;
        ST_MEASURE: begin
          if (frame_ok) state_d = ST_LOCKED;
          else          te_d    = 1'b1;
        end
        ST_LOCKED: begin
          if (frame_ok) begin
            fd_d = 1'b1;
          end else begin
            te_d    = 1'b1;
            state_d = ST_MEASURE;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  assign wr = (state_q == ST_LOCKED) && blank_s1;

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset)                       addr <= '0;
    else if (vs_fall)                addr <= '0;
    else if (wr && addr != A_MAX)    addr <= addr + 1'b1;
  end

  always_ff @(posedge vga_clock or posedge reset) begin
    if (reset) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      pix_q        <= '0;
      locked       <= 1'b0;
      frame_done   <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      we_q         <= wr;
      addr_q       <= addr;
      pix_q        <= rgb_s1;
      locked       <= (state_d == ST_LOCKED);
      frame_done   <= fd_d;
      timing_error <= te_d;
    end
  end

  assign mem.write_enable   = we_q;
  assign mem.memory_address = addr_q;
  assign mem.pixel_color    = COLOR_DEPTH'(pix_q);
endmodule

// File: tb/tb_vga_capture.sv
// Randomized bench: four DUTs (DATA_DELAY 0..3) on a reduced 16x6 geometry checked against a frame-level model.
module tb_vga_capture;
  localparam int COLS = 16;
  localparam int ROWS = 6;
  localparam int HBL  = 8;
  localparam int HTOT = COLS + HBL;
  localparam int VBL  = 4;
  localparam int ND   = 4;
  localparam int AMAX = COLS * ROWS - 1;

  typedef enum {M_SEARCH, M_MEASURE, M_LOCKED} mstate_t;

  typedef struct {
    bit         rst, blank, hs, vs;
    logic [7:0] r, g, b;
    bit         e_we, e_fd, e_te, e_lk;
    int         e_addr;
    logic [8:0] e_color;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       hs = 1'b1, vs = 1'b1, blank = 1'b0;
  logic [7:0] r_in [ND];
  logic [7:0] g_in [ND];
  logic [7:0] b_in [ND];

  logic        we_o   [ND];
  logic        lk_o   [ND];
  logic        fd_o   [ND];
  logic        te_o   [ND];
  logic [18:0] addr_o [ND];
  logic [8:0]  col_o  [ND];

  int checks = 0;
  int errors = 0;

  rec_t    st[$];
  mstate_t ms = M_SEARCH;
  int      maddr = 0;
  bit      prev_vs = 1'b1;
  bit      valid_prev = 1'b0;

  always #5 clk = ~clk;

  for (genvar d = 0; d < ND; d++) begin : g_dut
    vga_capture_if #(.Mn(19), .COLOR_DEPTH(9)) bus ();
    vga_capture #(
      .RESOLUTION("16x6"), .COLOR_DEPTH(9), .nX(10), .nY(9), .Mn(19),
      .COLS(COLS), .ROWS(ROWS), .DATA_DELAY(d)
    ) dut (
      .vga_clock(clk), .reset(rst),
      .VGA_R(r_in[d]), .VGA_G(g_in[d]), .VGA_B(b_in[d]),
      .VGA_HS(hs), .VGA_VS(vs), .VGA_BLANK_N(blank),
      .mem(bus),
      .locked(lk_o[d]), .frame_done(fd_o[d]), .timing_error(te_o[d])
    );
    assign we_o[d]   = bus.write_enable;
    assign addr_o[d] = bus.memory_address;
    assign col_o[d]  = bus.pixel_color;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: frame outcome decided at each VS fall from the previous frame's geometry.
  task automatic push(input bit rs, input bit bl, input bit h, input bit v,
                      input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input bit fc);
    rec_t e;
    e.rst = rs; e.blank = bl; e.hs = h; e.vs = v; e.r = r; e.g = g; e.b = b;
    e.e_we = 0; e.e_fd = 0; e.e_te = 0; e.e_lk = 0; e.e_addr = 0; e.e_color = '0;
    if (rs) begin
      ms = M_SEARCH; maddr = 0; prev_vs = 1'b1;
    end else begin
      if (prev_vs && !v) begin
        maddr = 0;
        case (ms)
          M_SEARCH:  ms = M_MEASURE;
          M_MEASURE: if (valid_prev) ms = M_LOCKED; else e.e_te = 1;
          M_LOCKED:  if (valid_prev) e.e_fd = 1; else begin e.e_te = 1; ms = M_MEASURE; end
        endcase
      end
      prev_vs = v;
      if (bl && ms == M_LOCKED) begin
        e.e_we    = 1;
        e.e_addr  = maddr;
        e.e_color = fc ? 9'b111000101 : {r[7:5], g[7:5], b[7:5]};
        if (maddr < AMAX) maddr++;
      end
      e.e_lk = (ms == M_LOCKED);
    end
    st.push_back(e);
  endtask

  task automatic emit_vblank();
    for (int ln = 0; ln < VBL; ln++)
      for (int c = 0; c < HTOT; c++)
        push(0, 0, !(c >= COLS + 2 && c < COLS + 5), !(ln == 1 || ln == 2),
             8'($urandom), 8'($urandom), 8'($urandom), 0);
  endtask

  // mode: 0 random colour, 1 fixed colour at (0,0), 2 ramp on line 0, 3 random geometry
  task automatic emit_frame(input int nrows, input int bad_row, input int bad_len,
                            input int mode, input int rst_at);
    int rows, len, rc;
    bit ok, fc, rs;
    logic [7:0] r, g, b;
    emit_vblank();
    rows = nrows;
    if (mode == 3) begin
      rc = int'($urandom_range(0, 5));
      rows = ROWS + (rc == 0 ? 1 : (rc == 1 ? -1 : 0));
    end
    ok = (rows == ROWS);
    for (int y = 0; y < rows; y++) begin
      len = (y == bad_row) ? bad_len : COLS;
      if (mode == 3) begin
        rc = int'($urandom_range(0, 19));
        if (rc == 0) len = COLS + 1;
        else if (rc == 1) len = COLS - 1;
      end
      if (len != COLS) ok = 0;
      for (int x = 0; x < len; x++) begin
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        if (mode == 2 && y == 0) begin r = 8'(x * 16); g = 8'(x * 16); b = 8'(x * 16); end
        fc = (mode == 1 && x == 0 && y == 0);
        if (fc) begin r = 8'hE0; g = 8'h1F; b = 8'hA5; end
        rs = (rst_at >= 0 && y == 1 && x >= rst_at && x < rst_at + 3);
        push(rs, 1, 1, 1, r, g, b, fc);
      end
      for (int c = 0; c < HBL; c++)
        push(0, 0, !(c >= 2 && c < 5), 1, 8'($urandom), 8'($urandom), 8'($urandom), 0);
    end
    valid_prev = ok;
  endtask

  task automatic check_rec(input int j);
    if (st[j].rst || (j + 1 < st.size() && st[j+1].rst)) return;
    for (int d = 0; d < ND; d++) begin
      check($sformatf("we%0d", d), 32'(we_o[d]), 32'(st[j].e_we));
      if (st[j].e_we) begin
        check($sformatf("addr%0d", d), 32'(addr_o[d]), 32'(st[j].e_addr));
        check($sformatf("color%0d", d), 32'(col_o[d]), 32'(st[j].e_color));
      end
      check($sformatf("frame_done%0d", d), 32'(fd_o[d]), 32'(st[j].e_fd));
      check($sformatf("timing_error%0d", d), 32'(te_o[d]), 32'(st[j].e_te));
      check($sformatf("locked%0d", d), 32'(lk_o[d]), 32'(st[j].e_lk));
    end
  endtask

  initial begin
    for (int d = 0; d < ND; d++) begin r_in[d] = '0; g_in[d] = '0; b_in[d] = '0; end
    for (int i = 0; i < 3; i++) push(1, 0, 1, 1, 8'h00, 8'h00, 8'h00, 0);
    emit_frame(ROWS, -1, 0, 0, -1);         // measured after first VS fall
    emit_frame(ROWS, -1, 0, 1, -1);         // locked; fixed colour at (0,0)
    emit_frame(ROWS, -1, 0, 2, -1);         // ramp on line 0
    emit_frame(ROWS, 2, COLS - 1, 0, -1);   // short line while locked
    emit_frame(ROWS, -1, 0, 0, -1);         // clean re-measure
    emit_frame(ROWS, -1, 0, 0, -1);
    emit_frame(ROWS + 1, -1, 0, 0, -1);     // extra line while locked: address saturates
    emit_frame(ROWS, 0, COLS + 1, 0, -1);   // long line in MEASURE
    emit_frame(ROWS + 1, -1, 0, 0, -1);     // extra line in MEASURE
    emit_frame(ROWS, -1, 0, 0, -1);
    for (int f = 0; f < 4; f++) emit_frame(ROWS, -1, 0, 3, -1);
    emit_frame(ROWS, -1, 0, 0, 5);          // reset mid-stream
    emit_frame(ROWS, -1, 0, 0, -1);
    emit_frame(ROWS, -1, 0, 2, -1);
    emit_frame(ROWS, -1, 0, 0, -1);
    emit_vblank();

    for (int k = 0; k < st.size() + 2; k++) begin
      @(negedge clk);
      if (k >= 2) check_rec(k - 2);
      if (k < st.size()) begin
        rst   = st[k].rst;
        blank = st[k].blank;
        hs    = st[k].hs;
        vs    = st[k].vs;
        for (int d = 0; d < ND; d++) begin
          if (k + d < st.size()) begin
            r_in[d] = st[k+d].r; g_in[d] = st[k+d].g; b_in[d] = st[k+d].b;
          end else begin
            r_in[d] = '0; g_in[d] = '0; b_in[d] = '0;
          end
        end
        if (st[k].rst && (k == 0 || !st[k-1].rst)) begin
          #1;
          for (int d = 0; d < ND; d++)
            check($sformatf("rst_zero%0d", d),
                  32'({we_o[d], addr_o[d], col_o[d], lk_o[d], fd_o[d], te_o[d]}), 32'd0);
        end
      end else begin
        rst = 1'b0; blank = 1'b0; hs = 1'b1; vs = 1'b1;
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
